// File: rtl/aes_state_buffer_if.sv
// Load/unload stream, round-datapath and status bundle for aes_state_buffer.
// master = the buffer itself, slave = the surrounding byte interface and round logic.
interface aes_state_buffer_if #(
    parameter int DATA_W  = 8,
    parameter int BLOCK_W = 128
);
    localparam int BEATS = BLOCK_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               load_done;
    logic [BLOCK_W-1:0] state;
    logic [BLOCK_W-1:0] dnext;
    logic               wen;
    logic               round_done;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic [CNT_W-1:0]   beat_cnt;

    modport master (
        input  in_data, in_valid, dnext, wen, round_done, out_ready,
        output in_ready, load_done, state, out_data, out_valid, busy, beat_cnt
    );

    modport slave (
        output in_data, in_valid, dnext, wen, round_done, out_ready,
        input  in_ready, load_done, state, out_data, out_valid, busy, beat_cnt
    );
endinterface

// File: rtl/aes_state_buffer.sv
// AES state register: packs DATA_W beats MSB-first, takes round updates, streams state back out.
// Latency: last load beat -> busy 1 cycle; round_done -> first out beat 1 cycle; turnaround 1 cycle.
// Backpressure: in_ready low outside LOAD; unload beat held stable while out_ready is low.
module aes_state_buffer #(
    parameter int DATA_W  = 8,
    parameter int BLOCK_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    aes_state_buffer_if.master bus
);
    localparam int BEATS = BLOCK_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    fsm_t                           fsm_q, fsm_d;
    logic [BEATS-1:0][DATA_W-1:0]   blk_q, blk_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CNT_W-1:0]               idx;
    logic                           load_done_q, load_done_d;
    logic                           last_beat;
    logic                           in_ready;
    logic                           out_valid;
    logic                           busy;

    // Beat 0 sits in the most significant slot of the packed array.
    assign idx       = CNT_W'(BEATS - 1) - cnt_q;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= LOAD;
            blk_q       <= '0;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (fsm_q)
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    blk_d[idx] = bus.in_data;
                    if (last_beat) begin
                        cnt_d       = '0;
                        fsm_d       = BUSY;
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                // A same-cycle wen and round_done drains the freshly written state.
                if (bus.wen)        blk_d = bus.dnext;
                if (bus.round_done) fsm_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        fsm_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                fsm_d = LOAD;
                cnt_d = '0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.load_done = load_done_q;
    assign bus.state     = blk_q;
    assign bus.beat_cnt  = cnt_q;
    assign bus.out_data  = out_valid ? blk_q[idx] : '0;
endmodule

// File: tb/tb_aes_state_buffer.sv
// Bench for aes_state_buffer: byte-wide instance for most scenarios, 32-bit instance for wide packing.
module tb_aes_state_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_state_buffer_if #(.DATA_W(8), .BLOCK_W(128)) bif ();
    aes_state_buffer #(.DATA_W(8), .BLOCK_W(128)) dut (.clk(clk), .rst(rst), .bus(bif.master));

    aes_state_buffer_if #(.DATA_W(32), .BLOCK_W(128)) wif ();
    aes_state_buffer #(.DATA_W(32), .BLOCK_W(128)) dut32 (.clk(clk), .rst(rst), .bus(wif.master));

    int checks   = 0;
    int failures = 0;
    bit [127:0] model_state;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.in_data = '0; bif.in_valid = 1'b0; bif.dnext = '0; bif.wen = 1'b0;
        bif.round_done = 1'b0; bif.out_ready = 1'b0;
        wif.in_data = '0; wif.in_valid = 1'b0; wif.dnext = '0; wif.wen = 1'b0;
        wif.round_done = 1'b0; wif.out_ready = 1'b0;
    endtask

    task automatic check_idle_load(input string tag, input bit [127:0] exp_state);
        #1;
        checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready got=%b exp=1", tag, bif.in_ready); end
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL %s busy got=%b exp=0", tag, bif.busy); end
        checks++; if (bif.out_valid !== 1'b0 || bif.out_data !== 8'h00) begin failures++; $display("FAIL %s out got v=%b d=%h exp v=0 d=00", tag, bif.out_valid, bif.out_data); end
        checks++; if (bif.load_done !== 1'b0) begin failures++; $display("FAIL %s load_done got=%b exp=0", tag, bif.load_done); end
        checks++; if (bif.beat_cnt !== 4'd0) begin failures++; $display("FAIL %s beat_cnt got=%0d exp=0", tag, bif.beat_cnt); end
        checks++; if (bif.state !== exp_state) begin failures++; $display("FAIL %s state got=%h exp=%h", tag, bif.state, exp_state); end
    endtask

    // Feed beats [from, upto) of blk with random valid gaps; a full block is checked on completion.
    task automatic load_beats(input bit [127:0] blk, input int from, input int upto, input int gap);
        int sent = from;
        int budget = 0;
        bit acc;
        while (sent < upto && budget < 400) begin
            bif.in_valid = ($urandom_range(99) >= gap);
            bif.in_data  = blk[127-8*sent -: 8];
            #1;
            checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready beat=%0d got=%b exp=1", sent, bif.in_ready); end
            acc = bif.in_valid && bif.in_ready;
            cyc();
            if (acc) begin
                model_state[127-8*sent -: 8] = blk[127-8*sent -: 8];
                sent++;
            end
            budget++;
        end
        bif.in_valid = 1'b0;
        checks++; if (sent != upto) begin failures++; $display("FAIL load_timeout sent=%0d exp=%0d", sent, upto); end
        if (upto == 16) begin
            checks++; if (bif.load_done !== 1'b1) begin failures++; $display("FAIL load_done_pulse got=%b exp=1", bif.load_done); end
            checks++; if (bif.busy !== 1'b1 || bif.in_ready !== 1'b0) begin failures++; $display("FAIL load_to_busy got busy=%b in_ready=%b exp 1/0", bif.busy, bif.in_ready); end
            checks++; if (bif.state !== blk) begin failures++; $display("FAIL load_state got=%h exp=%h", bif.state, blk); end
            checks++; if (bif.beat_cnt !== 4'd0) begin failures++; $display("FAIL load_cnt_wrap got=%0d exp=0", bif.beat_cnt); end
            cyc();
            checks++; if (bif.load_done !== 1'b0) begin failures++; $display("FAIL load_done_width got=%b exp=0", bif.load_done); end
        end
    endtask

    task automatic start_drain();
        bif.round_done = 1'b1;
        cyc();
        bif.round_done = 1'b0;
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random ready.
    task automatic drain_beats(input bit [127:0] exp, input int from, input int upto, input int mode);
        int got = from;
        int k = 0;
        bit rdy;
        while (got < upto && k < 500) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(1));
            endcase
            bif.out_ready = rdy;
            #1;
            checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== exp[127-8*got -: 8]) begin
                failures++; $display("FAIL drain_beat idx=%0d got v=%b d=%h exp v=1 d=%h", got, bif.out_valid, bif.out_data, exp[127-8*got -: 8]);
            end
            cyc();
            if (rdy) got++;
            k++;
        end
        bif.out_ready = 1'b0;
        checks++; if (got != upto) begin failures++; $display("FAIL drain_timeout got=%0d exp=%0d", got, upto); end
        if (mode == 0) begin
            checks++; if (k != upto - from) begin failures++; $display("FAIL drain_cycles got=%0d exp=%0d", k, upto - from); end
        end
        if (upto == 16) check_idle_load("drain_end", exp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
        model_state = '0;
        check_idle_load("reset", 128'h0);
        checks++; if (wif.in_ready !== 1'b1 || wif.state !== 128'h0 || wif.busy !== 1'b0) begin
            failures++; $display("FAIL reset_w32 got rdy=%b busy=%b state=%h exp 1/0/0", wif.in_ready, wif.busy, wif.state);
        end
    endtask

    task automatic test_load_bytes();
        bit [127:0] blk = 128'h000102030405060708090a0b0c0d0e0f;
        load_beats(blk, 0, 16, 0);
    endtask

    task automatic test_busy_wen();
        bit [127:0] a = {$urandom, $urandom, $urandom, $urandom};
        bit [127:0] b = {$urandom, $urandom, $urandom, $urandom};
        bif.wen = 1'b1; bif.dnext = a;
        cyc();
        #1;
        checks++; if (bif.state !== a || bif.busy !== 1'b1 || bif.out_valid !== 1'b0) begin
            failures++; $display("FAIL busy_wen got state=%h busy=%b ov=%b exp state=%h 1/0", bif.state, bif.busy, bif.out_valid, a);
        end
        bif.dnext = b; bif.round_done = 1'b1;
        cyc();
        bif.wen = 1'b0; bif.round_done = 1'b0; bif.dnext = '0;
        #1;
        checks++; if (bif.state !== b || bif.busy !== 1'b0 || bif.out_valid !== 1'b1 || bif.out_data !== b[127:120]) begin
            failures++; $display("FAIL busy_wen_done got state=%h busy=%b ov=%b od=%h exp state=%h 0/1 od=%h", bif.state, bif.busy, bif.out_valid, bif.out_data, b, b[127:120]);
        end
        model_state = b;
    endtask

    task automatic test_drain_stall();
        drain_beats(model_state, 0, 16, 1);
    endtask

    task automatic test_load_words32();
        bit [31:0] w [4];
        bit [127:0] exp;
        int sent = 0;
        int budget = 0;
        bit acc;
        foreach (w[i]) w[i] = $urandom;
        exp = {w[0], w[1], w[2], w[3]};
        while (sent < 4 && budget < 100) begin
            wif.in_valid = (budget % 3 == 2);
            wif.in_data  = w[sent];
            #1;
            acc = wif.in_valid && wif.in_ready;
            cyc();
            if (acc) sent++;
            budget++;
            if (acc && sent == 2) begin
                checks++; if (wif.state !== {w[0], w[1], 64'h0}) begin failures++; $display("FAIL w32_partial got=%h exp=%h", wif.state, {w[0], w[1], 64'h0}); end
            end
        end
        checks++; if (sent != 4) begin failures++; $display("FAIL w32_timeout sent=%0d exp=4", sent); end
        checks++; if (wif.load_done !== 1'b1 || wif.busy !== 1'b1) begin failures++; $display("FAIL w32_done got ld=%b busy=%b exp 1/1", wif.load_done, wif.busy); end
        wif.in_valid = 1'b1;
        wif.in_data  = 32'hdeadbeef;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (wif.in_ready !== 1'b0 || wif.state !== exp || wif.beat_cnt !== 2'd0) begin
                failures++; $display("FAIL w32_extra got rdy=%b state=%h cnt=%0d exp 0/%h/0", wif.in_ready, wif.state, wif.beat_cnt, exp);
            end
            cyc();
        end
        wif.in_valid = 1'b0;
    endtask

    task automatic test_reset_midway();
        bit [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
        load_beats(blk, 0, 7, 0);
        rst = 1'b1; bif.in_valid = 1'b1; bif.in_data = 8'h5a;
        cyc();
        rst = 1'b0; bif.in_valid = 1'b0;
        model_state = '0;
        check_idle_load("rst_mid_load", 128'h0);
        blk = {$urandom, $urandom, $urandom, $urandom};
        load_beats(blk, 0, 16, 20);
        start_drain();
        drain_beats(blk, 0, 5, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_state = '0;
        check_idle_load("rst_mid_drain", 128'h0);
        blk = {$urandom, $urandom, $urandom, $urandom};
        load_beats(blk, 0, 16, 0);
        start_drain();
        drain_beats(blk, 0, 16, 0);
    endtask

    task automatic test_ignored_ctrl();
        bit [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
        bit [127:0] partial;
        load_beats(blk, 0, 3, 0);
        partial = model_state;
        bif.wen = 1'b1; bif.round_done = 1'b1; bif.dnext = ~blk;
        cyc();
        bif.wen = 1'b0; bif.round_done = 1'b0;
        #1;
        checks++; if (bif.state !== partial || bif.beat_cnt !== 4'd3 || bif.busy !== 1'b0 || bif.in_ready !== 1'b1) begin
            failures++; $display("FAIL ctrl_in_load got state=%h cnt=%0d busy=%b rdy=%b exp %h/3/0/1", bif.state, bif.beat_cnt, bif.busy, bif.in_ready, partial);
        end
        load_beats(blk, 3, 16, 0);
        start_drain();
        drain_beats(blk, 0, 2, 0);
        bif.wen = 1'b1; bif.round_done = 1'b1; bif.out_ready = 1'b0;
        cyc();
        bif.wen = 1'b0; bif.round_done = 1'b0;
        #1;
        checks++; if (bif.state !== blk || bif.beat_cnt !== 4'd2 || bif.out_valid !== 1'b1 || bif.out_data !== blk[111:104]) begin
            failures++; $display("FAIL ctrl_in_drain got state=%h cnt=%0d ov=%b od=%h exp %h/2/1/%h", bif.state, bif.beat_cnt, bif.out_valid, bif.out_data, blk, blk[111:104]);
        end
        drain_beats(blk, 2, 16, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            bit [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
            int rounds = $urandom_range(3);
            load_beats(blk, 0, 16, 40);
            for (int r = 0; r < rounds; r++) begin
                bif.wen = 1'($urandom_range(1));
                bif.dnext = {$urandom, $urandom, $urandom, $urandom};
                if (bif.wen) model_state = bif.dnext;
                cyc();
            end
            bif.wen = 1'b0;
            start_drain();
            drain_beats(model_state, 0, 16, 2);
        end
    endtask

    initial begin
        test_reset();
        test_load_bytes();
        test_busy_wen();
        test_drain_stall();
        test_load_words32();
        test_reset_midway();
        test_ignored_ctrl();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
